// File: rtl/pc_pkg.sv
// Shared constants and state encoding for the popcount frame packer.
package pc_pkg;

    localparam int PC_IN_W  = 8;
    localparam int PC_VEC_W = 255;
    localparam int PC_BEATS = 32;
    localparam int PC_IDX_W = 5;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pc_state_t;

endpackage

// File: rtl/popcount_frame_packer.sv
// Packs up to 32 byte beats into a 255-bit vector for the downstream popcount stage,
// holding the frame on a valid/ready handshake until the consumer takes it.
module popcount_frame_packer
    import pc_pkg::*;
#(
    parameter int IN_W  = PC_IN_W,
    parameter int VEC_W = PC_VEC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [VEC_W-1:0] out_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_short
);

    pc_state_t             state;
    pc_state_t             state_nxt;
    logic [PC_IDX_W-1:0]   beat_idx;
    logic                  armed;
    logic [VEC_W-1:0]      vec;
    logic [VEC_W-1:0]      vec_nxt;
    logic [VEC_W:0]        lanes;
    logic                  short_q;
    logic                  accept;
    logic                  last_beat;
    logic                  close;

    // armed keeps s_ready low until the first edge after reset release
    assign s_ready   = armed & (state == FILL);
    assign out_valid = (state == HOLD);
    assign out_vec   = vec;
    assign out_short = short_q;

    assign accept    = s_valid & s_ready;
    assign last_beat = (beat_idx == PC_IDX_W'(PC_BEATS - 1));
    assign close     = accept & (s_last | last_beat);

    // Byte-lane write on a 256-bit scratch so beat 31 bit 7 simply falls off the top
    always_comb begin
        lanes = {1'b0, vec};
        if (accept) begin
            if (beat_idx == '0) begin
                lanes[VEC_W:IN_W] = '0;
            end
            lanes[{beat_idx, 3'b000} +: IN_W] = s_data;
        end
        vec_nxt = lanes[VEC_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (close)     state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            beat_idx <= '0;
            vec      <= '0;
            short_q  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            vec   <= vec_nxt;
            if (accept) begin
                beat_idx <= close ? '0 : beat_idx + PC_IDX_W'(1);
            end
            if (close) begin
                short_q <= s_last & ~last_beat;
            end
        end
    end

endmodule
